tff_count_ctrl: RTL
===================

# tff_count_ctrl

Sequencing controller for a bank of toggle flip-flops. It owns WIDTH one-bit toggle cells and drives their enable lines so the bank counts 0..limit as a synchronous up-counter. It signals completion with a one-cycle done pulse, then returns the bank to zero. It is the next layer above the single-bit toggle flip-flop in the lab sequence and is used wherever a bounded, startable and abortable count is needed.

## Interface
Parameters:
- WIDTH, 4, number of toggle cells and width of count and limit.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a count run; sampled only in IDLE.
- stop  in  1  abort the current run; effective in RUN.
- mod_val  in  WIDTH  terminal count, captured on an accepted start.
- q  out  WIDTH  bank state; concatenation of the cell outputs.
- tgl_en  out  WIDTH  enable vector presented to the cells this cycle (combinational from state and q).
- busy  out  1  high in RUN and DONE.
- done  out  1  high for exactly the one cycle spent in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, q=0, limit register=0, busy=0, done=0, tgl_en=0.
- IDLE:
  - start=1, stop=0, mod_val≠0: capture limit=mod_val and go to RUN.
  - start with mod_val=0: ignored, stay IDLE.
  - start and stop both high: stop wins, stay IDLE.
  - tgl_en=0 in this state.
- RUN, normal count:
  - If q≠limit: tgl_en[0]=1 and tgl_en[i]=&q[i-1:0]. This is a standard synchronous increment; q never wraps because the run ends at limit ≤ 2^WIDTH−1.
  - If q==limit: tgl_en=0, go to DONE.
- RUN, abort: stop=1 has priority over counting. tgl_en=q, which toggles every set bit, so q=0 next cycle. Go to IDLE with no done pulse.
- RUN, start: ignored. The limit register is not reloaded mid-run.
- DONE: done=1, tgl_en=q (clears bank), go to IDLE unconditionally. stop and start are ignored in this state.
- The limit register holds its value until the next accepted start.
- A cell toggles on a clock edge only when its enable is 1 and rst=0. rst overrides everything, in any state and at any count.

## Timing
- start sampled high at edge k (IDLE, valid mod_val=L) gives:
  - edge k: state RUN, q=0, busy=1.
  - edge k+n: q=n, for n=1..L.
  - edge k+L+1: state DONE, done=1, q=L.
  - edge k+L+2: state IDLE, q=0, busy=0, done=0.
- Total busy time is L+2 cycles. done is asserted 1 cycle after q first equals L.
- stop sampled at edge j in RUN: at edge j, state=IDLE, q=0, busy=0, done stays 0.
- A new start is accepted on the first cycle back in IDLE (edge k+L+2 sample), so back-to-back runs have 1 idle cycle between them.
- rst sampled mid-run: all outputs take their reset values at that edge. No done pulse is produced.
- busy and done are decoded from registered state and are glitch-free.

## Structure
- Package tff_ctrl_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default WIDTH constant.
- Sub-module tff_cell: ports clk, rst, en, q. Synchronous active-high reset to 0; toggles when en=1.
- tff_count_ctrl instantiates WIDTH tff_cell copies in a generate loop and contains:
  - the FSM;
  - the limit register;
  - the enable-vector logic.

## Test plan
- Reset: rst=1 for 2 cycles with random start/mod_val → q=0, busy=0, done=0, tgl_en=0 throughout.
- Basic run: mod_val=3, start pulse → q sequence 0,1,2,3,3,0 on successive edges; done high only on the second q=3 cycle; busy high for 5 cycles.
- Full range: WIDTH=4, mod_val=15 → q counts 0..15 with no wrap to 0 before DONE; tgl_en=4'b1111 observed on the 7→8 step; done after 16 cycles of RUN.
- Abort: mod_val=10, stop asserted when q=4 → q=0 and busy=0 next edge; done never asserted; an immediate start with mod_val=2 completes normally.
- Ignored requests:
  - start with mod_val=0 → stays IDLE.
  - start and stop together in IDLE → stays IDLE.
  - start with mod_val=9 during a run with limit=5 → run still ends at q=5.
- Reset mid-run: mod_val=12, rst pulsed at q=6 → q=0, state IDLE next edge, no done pulse, bank resumes cleanly on the next start.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared types and defaults for the toggle flip-flop count controller.
// Imported by the controller and its bench.
package tff_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: inverts its output on each clock where en is high.
// Synchronous active-high reset clears it to 0.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (en) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Drives a bank of toggle cells as a bounded synchronous up-counter 0..limit,
// pulses done for one cycle at the end and then clears the bank back to zero.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] tgl_en,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] carry;

  // Cell i toggles on increment when every lower cell is set.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      if (gi == 0) begin : g_lsb
        assign carry[gi] = 1'b1;
      end else begin : g_upper
        assign carry[gi] = carry[gi-1] & q[gi-1];
      end

      tff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .en  (tgl_en[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    tgl_en  = '0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (mod_val != '0)) begin
          limit_d = mod_val;
          state_d = RUN;
        end
      end
      RUN: begin
        // Toggling every set bit returns the bank to zero in one edge.
        if (stop) begin
          tgl_en  = q;
          state_d = IDLE;
        end else if (q != limit_q) begin
          tgl_en = carry;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        tgl_en  = q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);

endmodule
